// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed scan driver for a common-anode
// multi-digit 7-segment display. The display value is double-buffered. A new
// value is held in a shadow register and moved into the live display register
// only at a frame boundary, so a digit never shows part old, part new data.
// Optional feature: define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    val_valid_in,
  output logic                    val_ready_out,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_out
);

  localparam int CNT_W = $clog2(COUNT_PERIOD);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(COUNT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Value buffers: live display, pending shadow, shadow-occupied flag
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    full_q, full_d;

  // Registered outputs plus a one-cycle delayed boundary marker for frame_out
  logic [3:0]            nib_q, nib_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  bnd_q, bnd_d;
  logic                  frame_q, frame_d;

  logic                  tc;
  logic                  frame_bnd;
  logic                  accept;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] show_mask;

  assign tc        = (cnt_q == CNT_TC);
  assign frame_bnd = tc && (idx_q == IDX_LAST);
  assign accept    = val_valid_in && !full_q;

  // Tick counter and digit index advance
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (tc) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Update handshake; an accept landing on the boundary bypasses the shadow
  always_comb begin
    disp_d   = disp_q;
    shadow_d = shadow_q;
    full_d   = full_q;
    if (accept && frame_bnd) begin
      disp_d = val_in;
    end else if (accept) begin
      shadow_d = val_in;
      full_d   = 1'b1;
    end else if (frame_bnd && full_q) begin
      disp_d = shadow_q;
      full_d = 1'b0;
    end
  end

  // Digits allowed to light; with blanking, only up to the top nonzero nibble
`ifdef SEVEN_SEG_LZB_EN
  logic [IDX_W-1:0] msd;
  always_comb begin
    msd       = '0;
    show_mask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      show_mask[i] = (IDX_W'(i) <= msd);
    end
  end
`else
  assign show_mask = '1;
`endif

  // Output decode from the current index and display register
  always_comb begin
    sel   = '0;
    nib_d = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel[i] = 1'b1;
        nib_d  = disp_q[4*i +: 4];
      end
    end
    an_d    = ~(sel & digit_en_in & show_mask);
    bnd_d   = frame_bnd;
    frame_d = bnd_q;
  end

  // Control and output state, cleared by reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      full_q  <= 1'b0;
      nib_q   <= 4'h0;
      an_q    <= '1;
      bnd_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      full_q  <= full_d;
      nib_q   <= nib_d;
      an_q    <= an_d;
      bnd_q   <= bnd_d;
      frame_q <= frame_d;
    end
  end

  // Shadow data register; its contents only matter while full_q is set
  always_ff @(posedge clk_in) begin
    shadow_q <= shadow_d;
  end

  assign val_ready_out = !full_q;
  assign nibble_out    = nib_q;
  assign an_out        = an_q;
  assign frame_out     = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, COUNT_PERIOD=3.
// cyc counts clock edges since reset release. After edge cyc the display shows
// digit ((cyc-1)/3)%4. Frame boundaries fall on edges that are multiples of 12.
// frame_out is high after edges 13, 25, and so on.
module tb_seven_seg_scanner;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] val_in;
  logic        val_valid_in;
  logic        val_ready_out;
  logic [3:0]  digit_en_in;
  logic [3:0]  nibble_out;
  logic [3:0]  an_out;
  logic        frame_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk_in = ~clk_in;

  seven_seg_scanner #(
    .NUM_DIGITS  (4),
    .COUNT_PERIOD(3)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .val_in       (val_in),
    .val_valid_in (val_valid_in),
    .val_ready_out(val_ready_out),
    .digit_en_in  (digit_en_in),
    .nibble_out   (nibble_out),
    .an_out       (an_out),
    .frame_out    (frame_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  function automatic int digit_of(int c);
    return ((c - 1) / 3) % 4;
  endfunction

  function automatic logic [3:0] onehot(int d);
    logic [3:0] one;
    one = 4'b0001;
    return one << d;
  endfunction

  function automatic logic exp_frame(int c);
    return (c > 1) && (((c - 1) % 12) == 0);
  endfunction

  task automatic test_reset();
    rst_in       = 1'b1;
    val_valid_in = 1'b0;
    val_in       = 16'h0000;
    digit_en_in  = 4'hF;
    step();
    step();
    rst_in = 1'b0;
    cyc    = 0;
    checks++; if (an_out !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an_out); end
    checks++; if (nibble_out !== 4'h0) begin failures++; $display("FAIL reset_nibble got=%h exp=0", nibble_out); end
    checks++; if (val_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", val_ready_out); end
    checks++; if (frame_out !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_out); end
  endtask

  task automatic test_free_scan();
    logic [3:0] ea;
    for (int k = 0; k < 36; k++) begin
      step();
      ea = ~onehot(digit_of(cyc));
      checks++; if (an_out !== ea) begin failures++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an_out, ea); end
      checks++; if (frame_out !== exp_frame(cyc)) begin failures++; $display("FAIL scan_frame cyc=%0d got=%b exp=%b", cyc, frame_out, exp_frame(cyc)); end
      checks++; if (nibble_out !== 4'h0) begin failures++; $display("FAIL scan_nibble cyc=%0d got=%h exp=0", cyc, nibble_out); end
    end
  endtask

  task automatic test_update_mid_frame();
    logic [15:0] ev;
    logic [3:0]  en;
    ev = 16'h1234;
    while (cyc < 40) step();
    val_valid_in = 1'b1;
    val_in       = 16'h1234;
    step();
    val_valid_in = 1'b0;
    val_in       = 16'h0000;
    checks++; if (val_ready_out !== 1'b0) begin failures++; $display("FAIL upd_ready_drop cyc=%0d got=%b exp=0", cyc, val_ready_out); end
    while (cyc < 48) begin
      step();
      checks++; if (val_ready_out !== (cyc >= 48)) begin failures++; $display("FAIL upd_ready cyc=%0d got=%b exp=%b", cyc, val_ready_out, (cyc >= 48)); end
      checks++; if (nibble_out !== 4'h0) begin failures++; $display("FAIL upd_old_nibble cyc=%0d got=%h exp=0", cyc, nibble_out); end
    end
    while (cyc < 60) begin
      step();
      en = ev[4*digit_of(cyc) +: 4];
      checks++; if (nibble_out !== en) begin failures++; $display("FAIL upd_new_nibble cyc=%0d got=%h exp=%h", cyc, nibble_out, en); end
      checks++; if (val_ready_out !== 1'b1) begin failures++; $display("FAIL upd_ready_back cyc=%0d got=%b exp=1", cyc, val_ready_out); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ev;
    logic [3:0]  en;
    ev = 16'h1234;
    step();
    val_valid_in = 1'b1;
    val_in       = 16'h1234;
    step();
    checks++; if (val_ready_out !== 1'b0) begin failures++; $display("FAIL busy_ready cyc=%0d got=%b exp=0", cyc, val_ready_out); end
    val_in = 16'hABCD;
    step();
    step();
    val_valid_in = 1'b0;
    val_in       = 16'hFFFF;
    while (cyc < 72) begin
      step();
      en = ev[4*digit_of(cyc) +: 4];
      checks++; if (val_ready_out !== (cyc >= 72)) begin failures++; $display("FAIL busy_ready_hold cyc=%0d got=%b exp=%b", cyc, val_ready_out, (cyc >= 72)); end
      checks++; if (nibble_out !== en) begin failures++; $display("FAIL busy_nibble cyc=%0d got=%h exp=%h", cyc, nibble_out, en); end
    end
    while (cyc < 83) begin
      step();
      en = ev[4*digit_of(cyc) +: 4];
      checks++; if (nibble_out !== en) begin failures++; $display("FAIL ignored_nibble cyc=%0d got=%h exp=%h", cyc, nibble_out, en); end
    end
    val_valid_in = 1'b1;
    val_in       = 16'hABCD;
    step();
    val_valid_in = 1'b0;
    val_in       = 16'h0000;
    checks++; if (val_ready_out !== 1'b1) begin failures++; $display("FAIL bnd_accept_ready cyc=%0d got=%b exp=1", cyc, val_ready_out); end
    checks++; if (nibble_out !== 4'h1) begin failures++; $display("FAIL bnd_old_nibble cyc=%0d got=%h exp=1", cyc, nibble_out); end
    ev = 16'hABCD;
    while (cyc < 96) begin
      step();
      en = ev[4*digit_of(cyc) +: 4];
      checks++; if (nibble_out !== en) begin failures++; $display("FAIL bnd_new_nibble cyc=%0d got=%h exp=%h", cyc, nibble_out, en); end
      checks++; if (val_ready_out !== 1'b1) begin failures++; $display("FAIL bnd_ready cyc=%0d got=%b exp=1", cyc, val_ready_out); end
    end
  endtask

  task automatic test_digit_enable();
    logic [15:0] ev;
    logic [3:0]  en;
    logic [3:0]  ea;
    ev          = 16'hABCD;
    digit_en_in = 4'b0101;
    while (cyc < 108) begin
      step();
      ea = ~(onehot(digit_of(cyc)) & 4'b0101);
      en = ev[4*digit_of(cyc) +: 4];
      checks++; if (an_out !== ea) begin failures++; $display("FAIL en_an cyc=%0d got=%b exp=%b", cyc, an_out, ea); end
      checks++; if (nibble_out !== en) begin failures++; $display("FAIL en_nibble cyc=%0d got=%h exp=%h", cyc, nibble_out, en); end
      checks++; if (frame_out !== exp_frame(cyc)) begin failures++; $display("FAIL en_frame cyc=%0d got=%b exp=%b", cyc, frame_out, exp_frame(cyc)); end
    end
    digit_en_in = 4'hF;
  endtask

  task automatic test_blanking_and_reset();
    logic [15:0] ev;
    logic [3:0]  en;
    logic [3:0]  ea;
    logic [3:0]  lit;
    ev = 16'h0050;
    while (cyc < 119) step();
    val_valid_in = 1'b1;
    val_in       = 16'h0050;
    step();
    val_valid_in = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
    lit = 4'b0011;
`else
    lit = 4'b1111;
`endif
    while (cyc < 132) begin
      step();
      ea = ~(onehot(digit_of(cyc)) & lit);
      en = ev[4*digit_of(cyc) +: 4];
      checks++; if (an_out !== ea) begin failures++; $display("FAIL lzb_an cyc=%0d got=%b exp=%b", cyc, an_out, ea); end
      checks++; if (nibble_out !== en) begin failures++; $display("FAIL lzb_nibble cyc=%0d got=%h exp=%h", cyc, nibble_out, en); end
    end
    val_valid_in = 1'b1;
    val_in       = 16'h9999;
    step();
    val_valid_in = 1'b0;
    checks++; if (val_ready_out !== 1'b0) begin failures++; $display("FAIL pre_rst_ready cyc=%0d got=%b exp=0", cyc, val_ready_out); end
    step();
    rst_in = 1'b1;
    step();
    step();
    checks++; if (an_out !== 4'b1111) begin failures++; $display("FAIL midrst_an got=%b exp=1111", an_out); end
    checks++; if (nibble_out !== 4'h0) begin failures++; $display("FAIL midrst_nibble got=%h exp=0", nibble_out); end
    checks++; if (val_ready_out !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", val_ready_out); end
    checks++; if (frame_out !== 1'b0) begin failures++; $display("FAIL midrst_frame got=%b exp=0", frame_out); end
    rst_in = 1'b0;
    cyc    = 0;
`ifdef SEVEN_SEG_LZB_EN
    lit = 4'b0001;
`else
    lit = 4'b1111;
`endif
    while (cyc < 24) begin
      step();
      ea = ~(onehot(digit_of(cyc)) & lit);
      checks++; if (an_out !== ea) begin failures++; $display("FAIL post_rst_an cyc=%0d got=%b exp=%b", cyc, an_out, ea); end
      checks++; if (nibble_out !== 4'h0) begin failures++; $display("FAIL post_rst_nibble cyc=%0d got=%h exp=0", cyc, nibble_out); end
      checks++; if (val_ready_out !== 1'b1) begin failures++; $display("FAIL post_rst_ready cyc=%0d got=%b exp=1", cyc, val_ready_out); end
      checks++; if (frame_out !== exp_frame(cyc)) begin failures++; $display("FAIL post_rst_frame cyc=%0d got=%b exp=%b", cyc, frame_out, exp_frame(cyc)); end
    end
  endtask

  initial begin
    rst_in       = 1'b1;
    val_valid_in = 1'b0;
    val_in       = 16'h0000;
    digit_en_in  = 4'hF;
    test_reset();
    test_free_scan();
    test_update_mid_frame();
    test_back_to_back();
    test_digit_enable();
    test_blanking_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
